lvds_rx_checker: RTL

Pattern checker that consumes the 4-bit word stream captured by the LVDS receive path in the `rxclk` domain. It locks onto the transmitter's incrementing-counter pattern, then flywheels its own prediction so that one corrupted word counts as exactly one error. It accumulates error, word and lock-loss statistics, with a sticky per-lane error mask for locating a bad pair. It replaces the ad-hoc single-cycle compare, and its outputs feed the ILA and status registers.

---
 rtl/lvds_test_pkg.sv | 16 +
 rtl/lvds_rx_checker_sat_counter.sv | 26 ++
 rtl/lvds_rx_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lvds_test_pkg.sv
// Shared types and default parameters for the LVDS receive pattern checker.
// The width helper sizes the run counter for both lock and unlock thresholds.
package lvds_test_pkg;

    typedef enum logic {SEARCH, LOCKED} chk_state_t;

    localparam int DEF_LOCK_COUNT  = 16;
    localparam int DEF_UNLOCK_ERRS = 4;
    localparam int DEF_CNT_W       = 32;

    // Bits needed to hold any value up to and including max(a, b).
    function automatic int run_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lvds_rx_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides any increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/lvds_rx_checker.sv
// Locks onto the transmitter's incrementing counter, then flywheels its own
// prediction so each corrupted word is counted exactly once.
module lvds_rx_checker
    import lvds_test_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [WIDTH-1:0] lane_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int RUN_W = run_width(LOCK_COUNT, UNLOCK_ERRS);
    localparam int N_CNT = 3;

    chk_state_t       state_reg, state_next;
    logic [WIDTH-1:0] expected_reg, expected_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             seeded_reg, seeded_next;
    logic             error_reg, error_next;
    logic [WIDTH-1:0] lane_err_reg, lane_err_next;

    logic [WIDTH-1:0] lane_hit;
    logic [WIDTH-1:0] din_plus1;
    logic [RUN_W-1:0] run_inc;
    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [N_CNT];

    assign din_plus1 = din + WIDTH'(1);
    assign run_inc   = run_reg + RUN_W'(1);

    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        run_next      = run_reg;
        seeded_next   = seeded_reg;
        error_next    = 1'b0;
        lane_hit      = '0;
        cnt_inc       = '0;

        if (din_valid) begin
            case (state_reg)
                SEARCH: begin
                    // While searching the stream itself is the reference.
                    expected_next = din_plus1;
                    if (!seeded_reg) begin
                        seeded_next = 1'b1;
                        run_next    = '0;
                    end else if (din == expected_reg) begin
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: never reseed from din once locked.
                    expected_next = expected_reg + WIDTH'(1);
                    cnt_inc[1]    = 1'b1;
                    if (din != expected_reg) begin
                        error_next = 1'b1;
                        cnt_inc[0] = 1'b1;
                        lane_hit   = din ^ expected_reg;
                        if (run_inc == RUN_W'(UNLOCK_ERRS)) begin
                            state_next  = SEARCH;
                            seeded_next = 1'b0;
                            run_next    = '0;
                            cnt_inc[2]  = 1'b1;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end

        lane_err_next = clear ? '0 : (lane_err_reg | lane_hit);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= SEARCH;
            expected_reg <= '0;
            run_reg      <= '0;
            seeded_reg   <= 1'b0;
            error_reg    <= 1'b0;
            lane_err_reg <= '0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
            run_reg      <= run_next;
            seeded_reg   <= seeded_next;
            error_reg    <= error_next;
            lane_err_reg <= lane_err_next;
        end
    end

    // Index 0: errors, 1: words, 2: lock losses.
    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk    (clk),
                .resetn (resetn),
                .inc    (cnt_inc[gi]),
                .clr    (clear),
                .q      (cnt_q[gi])
            );
        end
    endgenerate

    assign locked     = (state_reg == LOCKED);
    assign error      = error_reg;
    assign lane_err   = lane_err_reg;
    assign err_count  = cnt_q[0];
    assign word_count = cnt_q[1];
    assign loss_count = cnt_q[2];

endmodule
